exit_gate_controller: RTL and testbench

Exit-side kiosk and barrier controller that drives the parking core's exit interface (car_exit, exit_from, exit_code).
- Collects a slot number and an 8-bit passcode from a keypad handshake.
- Pre-checks slot occupancy, then issues a one-cycle exit request to the core.
- Confirms success by watching that slot's occupancy bit clear, then opens the barrier for a bounded time.
- Counts consecutive failures and locks the keypad out after MAX_FAILS.

---
 rtl/parking_pkg.sv | 33 +++
 rtl/gate_timer.sv | 22 ++
 rtl/exit_gate_controller.sv | 136 +++++++++++++
 tb/tb_exit_gate_controller.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// parking_pkg: shared state encoding, widths and per-slot passcodes for the parking exit path
package parking_pkg;
    localparam int SLOT_W    = 3;
    localparam int CODE_W    = 8;
    localparam int NUM_SLOTS = 8;

    typedef enum logic [2:0] {
        IDLE,
        GET_CODE,
        REQUEST,
        WAIT_RESP,
        OPEN,
        REJECT,
        LOCKOUT
    } state_t;

    // Passcode for each slot: running sums of 1,2,3,5,8,13,21,34
    function automatic logic [CODE_W-1:0] slot_code(input logic [SLOT_W-1:0] slot);
        logic [CODE_W-1:0] a, b, t, sum;
        a   = 8'd1;
        b   = 8'd2;
        sum = 8'd1;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (i < int'(slot)) begin
                sum = sum + b;
                t   = a + b;
                a   = b;
                b   = t;
            end
        end
        return sum;
    endfunction
endpackage

// File: rtl/gate_timer.sv
// gate_timer: loadable down-counter that stops at zero and flags expiry
module gate_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);
    logic [W-1:0] cnt_q, cnt_d;

    // a load wins; otherwise count down and hold at zero
    always_comb cnt_d = load ? value : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);

    // counter register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    assign expired = cnt_q == '0;
endmodule

// File: rtl/exit_gate_controller.sv
// exit_gate_controller: keypad-driven exit request, occupancy-confirmed barrier and failure lockout.
// Build option EXIT_ENTRY_TIMEOUT_EN bounds the wait for the passcode byte with ENTRY_TIMEOUT cycles.
module exit_gate_controller
    import parking_pkg::*;
#(
    parameter int OPEN_CYCLES   = 16,
    parameter int RESP_WAIT     = 2,
    parameter int MAX_FAILS     = 3,
    parameter int LOCK_CYCLES   = 64,
    parameter int ENTRY_TIMEOUT = 32
) (
    input  logic              clock,
    input  logic              g1_reset_n,
    input  logic              key_valid,
    input  logic [7:0]        key_data,
    output logic              key_ready,
    input  logic [7:0]        occupied,
    input  logic              car_cleared,
    output logic              car_exit,
    output logic [SLOT_W-1:0] exit_from,
    output logic [CODE_W-1:0] exit_code,
    output logic              gate_open,
    output logic              result_ok,
    output logic              result_fail,
    output logic [2:0]        fail_count,
    output logic              locked
);
    localparam int M1   = OPEN_CYCLES > RESP_WAIT ? OPEN_CYCLES : RESP_WAIT;
    localparam int M2   = LOCK_CYCLES > ENTRY_TIMEOUT ? LOCK_CYCLES : ENTRY_TIMEOUT;
    localparam int TW   = $clog2(M1 > M2 ? M1 : M2) + 1;
`ifdef EXIT_ENTRY_TIMEOUT_EN
    localparam bit ENTRY_TO = 1'b1;
`else
    localparam bit ENTRY_TO = 1'b0;
`endif

    state_t            state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [2:0]        fail_q, fail_d, fail_inc;
    logic              load, expired, xfer, req_phase;
    logic [TW-1:0]     load_val;

    gate_timer #(.W(TW)) u_timer (
        .clk    (clock),
        .rst_n  (g1_reset_n),
        .load   (load),
        .value  (load_val),
        .expired(expired)
    );

    assign key_ready   = state_q == IDLE || state_q == GET_CODE;
    assign xfer        = key_valid && key_ready;
    assign req_phase   = state_q == REQUEST || state_q == WAIT_RESP;
    assign car_exit    = state_q == REQUEST;
    assign exit_from   = req_phase ? slot_q : '0;
    assign exit_code   = req_phase ? code_q : '0;
    assign gate_open   = state_q == OPEN;
    assign result_fail = state_q == REJECT;
    assign locked      = state_q == LOCKOUT;
    assign fail_count  = fail_q;
    assign fail_inc    = fail_q == 3'd7 ? 3'd7 : fail_q + 3'd1;

    // state, latched request and failure count registers
    always_ff @(posedge clock or negedge g1_reset_n)
        if (!g1_reset_n) begin
            state_q <= IDLE;
            slot_q  <= '0;
            code_q  <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            code_q  <= code_d;
            fail_q  <= fail_d;
        end

    // next state; durations load N-1 so the state lasts exactly N cycles
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        code_d    = code_q;
        fail_d    = fail_q;
        load      = 1'b0;
        load_val  = '0;
        result_ok = 1'b0;
        case (state_q)
            IDLE:
                if (xfer) begin
                    if (key_data[7:3] != '0 || !occupied[key_data[2:0]]) state_d = REJECT;
                    else begin
                        slot_d   = key_data[2:0];
                        state_d  = GET_CODE;
                        load     = ENTRY_TO;
                        load_val = TW'(ENTRY_TIMEOUT - 1);
                    end
                end
            GET_CODE:
                if (xfer) begin
                    code_d  = key_data;
                    state_d = REQUEST;
                end else if (ENTRY_TO && expired) state_d = REJECT;
            REQUEST: begin
                state_d  = WAIT_RESP;
                load     = 1'b1;
                load_val = TW'(RESP_WAIT);
            end
            WAIT_RESP:
                if (expired) begin
                    if (!occupied[slot_q]) begin
                        state_d   = OPEN;
                        result_ok = 1'b1;
                        fail_d    = '0;
                        load      = 1'b1;
                        load_val  = TW'(OPEN_CYCLES - 1);
                    end else state_d = REJECT;
                end
            OPEN:
                if (car_cleared || expired) state_d = IDLE;
            REJECT: begin
                fail_d = fail_inc;
                if (fail_inc >= 3'(MAX_FAILS)) begin
                    state_d  = LOCKOUT;
                    load     = 1'b1;
                    load_val = TW'(LOCK_CYCLES - 1);
                end else state_d = IDLE;
            end
            LOCKOUT:
                if (expired) begin
                    state_d = IDLE;
                    fail_d  = '0;
                end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_exit_gate_controller.sv
// tb_exit_gate_controller: directed exits, rejects, lockout and resets checked through an event scoreboard
module tb_exit_gate_controller;
    import parking_pkg::*;

    localparam int K_EXIT = 0, K_OK = 1, K_FAIL = 2, K_GATE = 3, K_LOCK = 4, K_RST = 5;

    typedef struct {
        int kind;
        int a;
        int b;
    } ev_t;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       key_valid = 1'b0, car_cleared = 1'b0;
    logic [7:0] key_data = '0;
    logic [7:0] occ, occ_load_val = '0;
    logic       occ_load = 1'b1;
    logic       key_ready, car_exit, gate_open, result_ok, result_fail, locked;
    logic [2:0] exit_from, fail_count;
    logic [7:0] exit_code;

    ev_t sb[$];
    int  vectors = 0, miscompares = 0;
    int  glen = 0, llen = 0, since = 0;
    bit  lready = 0, fail_seen = 0, rst_seen = 0, done = 0;

    exit_gate_controller dut (
        .clock      (clk),
        .g1_reset_n (rst_n),
        .key_valid  (key_valid),
        .key_data   (key_data),
        .key_ready  (key_ready),
        .occupied   (occ),
        .car_cleared(car_cleared),
        .car_exit   (car_exit),
        .exit_from  (exit_from),
        .exit_code  (exit_code),
        .gate_open  (gate_open),
        .result_ok  (result_ok),
        .result_fail(result_fail),
        .fail_count (fail_count),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    // parking core model: clears the slot one cycle after a request carrying the right code
    always @(posedge clk)
        if (occ_load) occ <= occ_load_val;
        else if (car_exit && occ[exit_from] && exit_code == slot_code(exit_from)) occ[exit_from] <= 1'b0;

    task automatic push(input int kind, input int a, input int b);
        sb.push_back('{kind, a, b});
    endtask

    task automatic check_ev(input int kind, input int a, input int b, input string nm);
        ev_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s: got kind=%0d a=%0d b=%0d, expected no event", nm, kind, a, b);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.a != a || e.b != b) begin
                miscompares++;
                $display("FAIL %s: got kind=%0d a=%0d b=%0d, expected kind=%0d a=%0d b=%0d",
                         nm, kind, a, b, e.kind, e.a, e.b);
            end
        end
    endtask

    // monitor: turns DUT outputs into events and compares them against the queue
    always @(negedge clk) begin
        if (done) begin
            vectors++;
            if (sb.size() != 0) begin
                miscompares++;
                $display("FAIL scoreboard_drain: %0d events still pending, expected 0", sb.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end else if (!rst_n) begin
            if (!rst_seen)
                check_ev(K_RST, int'({key_ready, gate_open, car_exit, locked, result_ok, result_fail}),
                         int'({fail_count, exit_from, exit_code}), "reset_state");
            rst_seen  = 1;
            glen      = 0;
            llen      = 0;
            lready    = 0;
            fail_seen = 0;
        end else begin
            rst_seen = 0;
            if (fail_seen) check_ev(K_FAIL, int'(fail_count), 0, "reject_count");
            fail_seen = result_fail;
            if (car_exit) begin
                since = 0;
                check_ev(K_EXIT, int'(exit_from), int'(exit_code), "exit_request");
            end else since++;
            if (result_ok) check_ev(K_OK, since, 0, "result_ok_latency");
            if (gate_open) glen++;
            else if (glen != 0) begin
                check_ev(K_GATE, glen, 0, "gate_open_cycles");
                glen = 0;
            end
            if (locked) begin
                llen++;
                lready = lready | key_ready;
            end else if (llen != 0) begin
                check_ev(K_LOCK, llen, int'(lready) * 100 + int'(key_ready) * 10 + int'(fail_count), "lockout");
                llen   = 0;
                lready = 0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_occ(input logic [7:0] v);
        occ_load_val = v;
        occ_load     = 1'b1;
        idle(1);
        occ_load = 1'b0;
    endtask

    task automatic send_key(input logic [7:0] b);
        bit got = 0;
        key_data  = b;
        key_valid = 1'b1;
        for (int i = 0; i < 200; i++)
            if (!got) begin
                got = key_ready;
                idle(1);
            end
        key_valid = 1'b0;
        key_data  = '0;
        if (!got) begin
            $display("FAIL key_handshake: key_ready stayed 0, expected 1");
            $fatal(1);
        end
    endtask

    task automatic wait_gate(input logic lvl);
        bit got = 0;
        for (int i = 0; i < 200; i++)
            if (!got) begin
                idle(1);
                got = gate_open == lvl;
            end
        if (!got) begin
            $display("FAIL gate_wait: gate_open=%0b, expected %0b", gate_open, lvl);
            $fatal(1);
        end
    endtask

    task automatic do_reset();
        push(K_RST, 32, 0);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    initial begin
        push(K_RST, 32, 0);
        idle(2);
        rst_n    = 1'b1;
        occ_load = 1'b0;
        // 1: slot 3 good exit, car clears in the fifth open cycle
        set_occ(8'h08);
        push(K_EXIT, 3, 11); push(K_OK, 3, 0); push(K_GATE, 5, 0);
        send_key(8'd3); send_key(8'd11);
        wait_gate(1'b1);
        idle(4);
        car_cleared = 1'b1;
        idle(1);
        car_cleared = 1'b0;
        // 2: wrong code for slot 7, core keeps it occupied
        set_occ(8'h80);
        push(K_EXIT, 7, 86); push(K_FAIL, 1, 0);
        send_key(8'd7); send_key(8'd86);
        idle(8);
        do_reset();
        // 3: three consecutive wrong codes lock the keypad for 64 cycles
        push(K_EXIT, 7, 86);  push(K_FAIL, 1, 0);
        push(K_EXIT, 7, 0);   push(K_FAIL, 2, 0);
        push(K_EXIT, 7, 200); push(K_FAIL, 3, 0); push(K_LOCK, 64, 10);
        send_key(8'd7); send_key(8'd86);
        send_key(8'd7); send_key(8'd0);
        send_key(8'd7); send_key(8'd200);
        // 4: empty slot and malformed slot byte reject without a request
        push(K_FAIL, 1, 0);
        send_key(8'd5);
        push(K_FAIL, 2, 0);
        send_key(8'h09);
        // 5: good exit with no car_cleared holds the gate for the full window
        set_occ(8'h04);
        push(K_EXIT, 2, 6); push(K_OK, 3, 0); push(K_GATE, 16, 0);
        send_key(8'd2); send_key(8'd6);
        wait_gate(1'b1);
        wait_gate(1'b0);
`ifdef EXIT_ENTRY_TIMEOUT_EN
        push(K_FAIL, 1, 0);
        send_key(8'd2);
        idle(40);
`endif
        // 6: reset while the gate is open, then while waiting for the core
        set_occ(8'h08);
        push(K_EXIT, 3, 11); push(K_OK, 3, 0);
        send_key(8'd3); send_key(8'd11);
        wait_gate(1'b1);
        idle(1);
        do_reset();
        set_occ(8'h08);
        push(K_EXIT, 3, 11);
        send_key(8'd3); send_key(8'd11);
        idle(1);
        do_reset();
        push(K_FAIL, 1, 0);
        send_key(8'h09);
        idle(6);
        done = 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected finish earlier");
        $fatal(1);
    end
endmodule
